// File: rtl/hazard3_muldiv_seq_pkg.sv
// Shared constants for the M-extension sequencer: mulop codes, FSM states and
// operand-signedness decode helpers.
package hazard3_muldiv_seq_pkg;

    localparam logic [2:0] M_OP_MUL    = 3'd0;
    localparam logic [2:0] M_OP_MULH   = 3'd1;
    localparam logic [2:0] M_OP_MULHSU = 3'd2;
    localparam logic [2:0] M_OP_MULHU  = 3'd3;
    localparam logic [2:0] M_OP_DIV    = 3'd4;
    localparam logic [2:0] M_OP_DIVU   = 3'd5;
    localparam logic [2:0] M_OP_REM    = 3'd6;
    localparam logic [2:0] M_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'd0,
        MULDIV_ST_RUN  = 2'd1,
        MULDIV_ST_DONE = 2'd2
    } muldiv_st_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == M_OP_MULH) || (op == M_OP_MULHSU) ||
               (op == M_OP_DIV)  || (op == M_OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == M_OP_MULH) || (op == M_OP_DIV) || (op == M_OP_REM);
    endfunction

endpackage

// File: rtl/hazard3_muldiv_seq_if.sv
// Execute-stage request/result handshake of the mul/div sequencer.
interface hazard3_muldiv_seq_if #(
    parameter int XLEN    = 32,
    parameter int W_MULOP = 3
);
    logic               op_vld;
    logic               op_rdy;
    logic [W_MULOP-1:0] op;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic               op_kill;
    logic [XLEN-1:0]    result;
    logic               result_vld;
    logic               result_rdy;
    logic               busy;

    modport master (
        output op_vld, op, op_a, op_b, op_kill, result_rdy,
        input  op_rdy, result, result_vld, busy
    );

    modport slave (
        input  op_vld, op, op_a, op_b, op_kill, result_rdy,
        output op_rdy, result, result_vld, busy
    );
endinterface

// File: rtl/hazard3_muldiv_step.sv
// One radix-2 iteration of the shared datapath: shift-add multiply or
// restoring divide, selected by i_div. Purely combinational.
module hazard3_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN:0]   i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN:0]   o_hi,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN:0]   w_sum;
    logic [XLEN+1:0] w_trial;
    logic [XLEN+1:0] w_diff;
    logic            w_ge;

    // Iteration arithmetic; the divide borrow is the sign of the widened difference
    always_comb begin
        w_sum   = i_hi + {1'b0, (i_lo[0] ? i_b : {XLEN{1'b0}})};
        w_trial = {i_hi, i_lo[XLEN-1]};
        w_diff  = w_trial - {2'b00, i_b};
        w_ge    = ~w_diff[XLEN+1];
        if (i_div) begin
            o_hi = w_ge ? w_diff[XLEN:0] : w_trial[XLEN:0];
            o_lo = {i_lo[XLEN-2:0], w_ge};
        end else begin
            o_hi = {1'b0, w_sum[XLEN:1]};
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/hazard3_muldiv_seq.sv
// Iterative RISC-V M-extension sequencer: runs MUL*/DIV*/REM* on operand
// magnitudes over XLEN/UNROLL cycles and returns a signed-corrected result.
module hazard3_muldiv_seq
    import hazard3_muldiv_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int UNROLL  = 1,
    parameter int W_MULOP = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard3_muldiv_seq_if.slave bus
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    muldiv_st_t         r_state;
    muldiv_st_t         w_state_nxt;
    logic [W_MULOP-1:0] r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN:0]      r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_b;
    logic [CW-1:0]      r_count;
    logic [XLEN-1:0]    r_result;

    logic               w_accept, w_step, w_last;
    logic               w_sa, w_sb;
    logic [XLEN-1:0]    w_abs_a, w_abs_b;
    logic               w_neg_q_in, w_neg_r_in;
    logic [2*XLEN-1:0]  w_prod, w_prod_c;
    logic [XLEN-1:0]    w_quo, w_rem, w_res;
    logic               w_unused;

    logic [XLEN:0]      w_hi_chain [UNROLL+1];
    logic [XLEN-1:0]    w_lo_chain [UNROLL+1];

    assign w_hi_chain[0] = r_hi;
    assign w_lo_chain[0] = r_lo;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        hazard3_muldiv_step #(.XLEN(XLEN)) u_step (
            .i_div (op_is_div(r_op)),
            .i_hi  (w_hi_chain[g]),
            .i_lo  (w_lo_chain[g]),
            .i_b   (r_b),
            .o_hi  (w_hi_chain[g+1]),
            .o_lo  (w_lo_chain[g+1])
        );
    end

    // Multiply high word never reaches bit XLEN; a divide remainder is below the divisor
    assign w_unused = w_hi_chain[UNROLL][XLEN];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MULDIV_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; kill always wins
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            MULDIV_ST_IDLE: begin
                if (bus.op_kill) begin
                    w_state_nxt = MULDIV_ST_IDLE;
                end else if (bus.op_vld) begin
                    w_state_nxt = MULDIV_ST_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = MULDIV_ST_IDLE;
                end
            end
            MULDIV_ST_RUN: begin
                if (bus.op_kill) begin
                    w_state_nxt = MULDIV_ST_IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_state_nxt = MULDIV_ST_DONE;
                    w_step      = 1'b1;
                    w_last      = 1'b1;
                end else begin
                    w_state_nxt = MULDIV_ST_RUN;
                    w_step      = 1'b1;
                end
            end
            MULDIV_ST_DONE: begin
                if (bus.op_kill || bus.result_rdy) begin
                    w_state_nxt = MULDIV_ST_IDLE;
                end else begin
                    w_state_nxt = MULDIV_ST_DONE;
                end
            end
            default: w_state_nxt = MULDIV_ST_IDLE;
        endcase
    end

    // Operand magnitudes and sign-correction flags at accept
    always_comb begin
        w_sa       = op_a_signed(bus.op) & bus.op_a[XLEN-1];
        w_sb       = op_b_signed(bus.op) & bus.op_b[XLEN-1];
        w_abs_a    = w_sa ? -bus.op_a : bus.op_a;
        w_abs_b    = w_sb ? -bus.op_b : bus.op_b;
        w_neg_q_in = (w_sa ^ w_sb) & (~op_is_div(bus.op) | (|bus.op_b));
        w_neg_r_in = w_sa & op_is_div(bus.op);
    end

    // Final correction. Divide-by-zero and overflow fall out of the restoring
    // algorithm: d=0 yields all-ones quotient and remainder |a|.
    always_comb begin
        w_prod   = {w_hi_chain[UNROLL][XLEN-1:0], w_lo_chain[UNROLL]};
        w_prod_c = r_neg_q ? -w_prod : w_prod;
        w_quo    = r_neg_q ? -w_lo_chain[UNROLL] : w_lo_chain[UNROLL];
        w_rem    = r_neg_r ? -w_hi_chain[UNROLL][XLEN-1:0] : w_hi_chain[UNROLL][XLEN-1:0];
        case (r_op)
            M_OP_MUL:                            w_res = w_prod_c[XLEN-1:0];
            M_OP_MULH, M_OP_MULHSU, M_OP_MULHU:  w_res = w_prod_c[2*XLEN-1:XLEN];
            M_OP_DIV, M_OP_DIVU:                 w_res = w_quo;
            M_OP_REM, M_OP_REMU:                 w_res = w_rem;
            default:                             w_res = {XLEN{1'b0}};
        endcase
    end

    // Operand latch, accumulator, iteration count and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= {W_MULOP{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= {(XLEN+1){1'b0}};
            r_lo     <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_count  <= {CW{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_op    <= bus.op;
            r_neg_q <= w_neg_q_in;
            r_neg_r <= w_neg_r_in;
            r_hi    <= {(XLEN+1){1'b0}};
            r_lo    <= w_abs_a;
            r_b     <= w_abs_b;
            r_count <= {CW{1'b0}};
        end else if (w_step) begin
            r_hi <= w_hi_chain[UNROLL];
            r_lo <= w_lo_chain[UNROLL];
            if (w_last) begin
                r_result <= w_res;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign bus.op_rdy     = (r_state == MULDIV_ST_IDLE);
    assign bus.result_vld = (r_state == MULDIV_ST_DONE);
    assign bus.busy       = (r_state != MULDIV_ST_IDLE);
    assign bus.result     = r_result;
endmodule

// File: tb/tb_hazard3_muldiv_seq.sv
// Directed bench for hazard3_muldiv_seq: arithmetic corner cases, latency,
// kill, result back-pressure and asynchronous reset.
module tb_hazard3_muldiv_seq;
    import hazard3_muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    hazard3_muldiv_seq_if #(.XLEN(32), .W_MULOP(3)) bus ();

    hazard3_muldiv_seq #(.XLEN(32), .UNROLL(1), .W_MULOP(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge; returns at the negedge of cycle 1 with operands scrambled
    task automatic start_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (!bus.op_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " rdy"}, 32'(bus.op_rdy), 32'd1);
        bus.op     = op;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.op_vld = 1'b1;
        @(negedge clk);
        bus.op_vld = 1'b0;
        bus.op     = M_OP_MULHU;
        bus.op_a   = 32'hDEADBEEF;
        bus.op_b   = 32'h0BADF00D;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int lat;
        bus.result_rdy = (hold == 0);
        start_op(tag, op, a, b);
        lat = 1;
        while (!bus.result_vld && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd33);
        check(tag, bus.result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold vld"}, 32'(bus.result_vld), 32'd1);
            check({tag, " hold res"}, bus.result, exp);
            check({tag, " hold rdy"}, 32'(bus.op_rdy), 32'd0);
        end
        bus.result_rdy = 1'b1;
        @(negedge clk);
        check({tag, " op_rdy after"}, 32'(bus.op_rdy), 32'd1);
        check({tag, " vld after"}, 32'(bus.result_vld), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bus.op_vld     = 1'b0;
        bus.op_kill    = 1'b0;
        bus.op         = 3'd0;
        bus.op_a       = 32'd0;
        bus.op_b       = 32'd0;
        bus.result_rdy = 1'b1;
        @(negedge clk);
        check("reset op_rdy", 32'(bus.op_rdy), 32'd1);
        check("reset result_vld", 32'(bus.result_vld), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL 7*6",        M_OP_MUL,    32'd7,          32'd6,          32'h0000002A, 0);
        run_op("MULH -1*-1",     M_OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 0);
        run_op("MULHU max*max",  M_OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 0);
        run_op("MULHSU -1*2",    M_OP_MULHSU, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF, 0);
        run_op("MULH min*min",   M_OP_MULH,   32'h80000000,   32'h80000000,   32'h40000000, 0);
        run_op("DIV -7/2",       M_OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 0);
        run_op("REM -7/2",       M_OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 0);
        run_op("DIVU big/2",     M_OP_DIVU,   32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC, 0);
        run_op("REMU 100/7",     M_OP_REMU,   32'd100,        32'd7,          32'd2,        0);
        run_op("DIV by 0",       M_OP_DIV,    32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF, 0);
        run_op("REM by 0",       M_OP_REM,    32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9, 0);
        run_op("REMU by 0",      M_OP_REMU,   32'd5,          32'd0,          32'd5,        0);
        run_op("DIV overflow",   M_OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000, 0);
        run_op("REM overflow",   M_OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'h00000000, 0);

        // Kill in RUN cycle 10, then a fresh op the cycle after
        start_op("kill op", M_OP_MUL, 32'd5, 32'd5);
        for (int c = 1; c < 10; c++) begin
            check("kill pre vld", 32'(bus.result_vld), 32'd0);
            @(negedge clk);
        end
        bus.op_kill = 1'b1;
        @(negedge clk);
        bus.op_kill = 1'b0;
        check("kill busy", 32'(bus.busy), 32'd0);
        check("kill op_rdy", 32'(bus.op_rdy), 32'd1);
        check("kill vld", 32'(bus.result_vld), 32'd0);
        run_op("MUL 3*3 after kill", M_OP_MUL, 32'd3, 32'd3, 32'd9, 0);

        // Kill beats a simultaneous request in IDLE
        bus.op_vld  = 1'b1;
        bus.op_kill = 1'b1;
        bus.op      = M_OP_MUL;
        @(negedge clk);
        bus.op_vld  = 1'b0;
        bus.op_kill = 1'b0;
        check("kill+vld busy", 32'(bus.busy), 32'd0);
        check("kill+vld op_rdy", 32'(bus.op_rdy), 32'd1);

        run_op("DIV 100/7 stall", M_OP_DIV, 32'd100, 32'd7, 32'd14, 5);

        // Asynchronous reset mid-RUN
        start_op("reset op", M_OP_MUL, 32'd11, 32'd13);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst op_rdy", 32'(bus.op_rdy), 32'd1);
        check("async rst vld", 32'(bus.result_vld), 32'd0);
        check("async rst busy", 32'(bus.busy), 32'd0);
        check("async rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("MUL after reset", M_OP_MUL, 32'd11, 32'd13, 32'd143, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
